// File: rtl/am2950_io_port_pkg.sv
// rtl/am2950_io_port_pkg.sv - shared constants and types for the am2950 I/O port
package am2950_io_port_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef struct packed {
    logic full;
    logic ovr;
  } chan_flags_t;

endpackage

// File: rtl/am2950_io_port_if.sv
// rtl/am2950_io_port_if.sv - control strobes and status flags of the am2950 I/O port
interface am2950_io_port_if;

  logic a_ld;
  logic b_ld;
  logic a_oe_;
  logic b_oe_;
  logic r_ack;
  logic s_ack;
  logic ier;
  logic ies;
  logic ovr_clr;

  logic fr;
  logic fs;
  logic ovr_r;
  logic ovr_s;
  logic int_;

  modport master (
    output a_ld, b_ld, a_oe_, b_oe_, r_ack, s_ack, ier, ies, ovr_clr,
    input  fr, fs, ovr_r, ovr_s, int_
  );

  modport slave (
    input  a_ld, b_ld, a_oe_, b_oe_, r_ack, s_ack, ier, ies, ovr_clr,
    output fr, fs, ovr_r, ovr_s, int_
  );

endinterface

// File: rtl/am2950_chan.sv
// rtl/am2950_chan.sv - one holding register with full and sticky overrun flags
module am2950_chan
  import am2950_io_port_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ld,
  input  logic             ack,
  input  logic             ovr_clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output chan_flags_t      flags
);

  logic accept;
  logic reject;

  // An ack in the same cycle frees the slot, so a load against a full register still lands.
  assign accept = ld & (~flags.full | ack);
  assign reject = ld & flags.full & ~ack;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      q     <= '0;
      flags <= '0;
    end else begin
      if (accept) begin
        q          <= d;
        flags.full <= 1'b1;
      end else if (ack) begin
        flags.full <= 1'b0;
      end

      // A fresh overrun outranks a simultaneous clear.
      if (reject) begin
        flags.ovr <= 1'b1;
      end else if (ovr_clr) begin
        flags.ovr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/am2950_io_port.sv
// rtl/am2950_io_port.sv - 8-bit bidirectional I/O port with handshake flags (am2950)
module am2950_io_port
  import am2950_io_port_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  am2950_io_port_if.slave  ctl
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] s_q;
  chan_flags_t      r_flags;
  chan_flags_t      s_flags;

  am2950_chan #(.WIDTH(WIDTH)) u_r (
    .clk     (clk),
    .rst_    (rst_),
    .ld      (ctl.a_ld),
    .ack     (ctl.r_ack),
    .ovr_clr (ctl.ovr_clr),
    .d       (a),
    .q       (r_q),
    .flags   (r_flags)
  );

  am2950_chan #(.WIDTH(WIDTH)) u_s (
    .clk     (clk),
    .rst_    (rst_),
    .ld      (ctl.b_ld),
    .ack     (ctl.s_ack),
    .ovr_clr (ctl.ovr_clr),
    .d       (b),
    .q       (s_q),
    .flags   (s_flags)
  );

  // Reset overrides the enables so neither bus is driven while the port is held in reset.
  assign a = (rst_ && !ctl.a_oe_) ? s_q : {WIDTH{1'bz}};
  assign b = (rst_ && !ctl.b_oe_) ? r_q : {WIDTH{1'bz}};

  assign ctl.fr    = r_flags.full;
  assign ctl.fs    = s_flags.full;
  assign ctl.ovr_r = r_flags.ovr;
  assign ctl.ovr_s = s_flags.ovr;
  assign ctl.int_  = ~((r_flags.full & ctl.ier) | (s_flags.full & ctl.ies));

endmodule

// File: tb/tb_am2950_io_port.sv
// tb/tb_am2950_io_port.sv - directed self-checking bench for am2950_io_port
module tb_am2950_io_port;

  logic       clk = 1'b0;
  logic       rst_;
  wire  [7:0] a_bus;
  wire  [7:0] b_bus;
  logic [7:0] a_drv;
  logic [7:0] b_drv;
  logic       a_en;
  logic       b_en;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  // Bench-side drivers; undriven bus bits are pulled high so a released bus reads 8'hFF.
  assign a_bus = a_en ? a_drv : 8'hzz;
  assign b_bus = b_en ? b_drv : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (a_bus[i]);
    pullup (b_bus[i]);
  end

  am2950_io_port_if ctl ();

  am2950_io_port #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .a    (a_bus),
    .b    (b_bus),
    .ctl  (ctl.slave)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_flags(input string tag, input logic fr, input logic fs,
                           input logic ovr_r, input logic ovr_s, input logic int_);
    chk1({tag, ".fr"}, ctl.fr, fr);
    chk1({tag, ".fs"}, ctl.fs, fs);
    chk1({tag, ".ovr_r"}, ctl.ovr_r, ovr_r);
    chk1({tag, ".ovr_s"}, ctl.ovr_s, ovr_s);
    chk1({tag, ".int_"}, ctl.int_, int_);
  endtask

  initial begin
    rst_        = 1'b0;
    a_en        = 1'b0;
    b_en        = 1'b0;
    a_drv       = 8'h00;
    b_drv       = 8'h00;
    ctl.a_ld    = 1'b0;
    ctl.b_ld    = 1'b0;
    ctl.a_oe_   = 1'b0;
    ctl.b_oe_   = 1'b0;
    ctl.r_ack   = 1'b0;
    ctl.s_ack   = 1'b0;
    ctl.ier     = 1'b0;
    ctl.ies     = 1'b0;
    ctl.ovr_clr = 1'b0;

    // Reset with both enables low: buses released, flags clear.
    tick;
    tick;
    chk8("rst.a_z", a_bus, 8'hFF);
    chk8("rst.b_z", b_bus, 8'hFF);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    rst_ = 1'b1;
    #1;
    chk8("rel.a", a_bus, 8'h00);
    chk8("rel.b", b_bus, 8'h00);
    ctl.a_oe_ = 1'b1;
    ctl.b_oe_ = 1'b1;
    #1;
    chk8("oe_off.a", a_bus, 8'hFF);
    @(negedge clk);

    // R transfer and ack.
    a_en = 1'b1; a_drv = 8'hA5; ctl.a_ld = 1'b1; ctl.ier = 1'b1;
    tick;
    ctl.a_ld = 1'b0; a_en = 1'b0;
    chk_flags("rx", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ctl.b_oe_ = 1'b0;
    #1;
    chk8("rx.b", b_bus, 8'hA5);
    ctl.r_ack = 1'b1;
    tick;
    ctl.r_ack = 1'b0;
    chk_flags("rack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk8("rack.stale_b", b_bus, 8'hA5);

    // R overrun: second load rejected, R keeps first value.
    a_en = 1'b1; a_drv = 8'h11; ctl.a_ld = 1'b1;
    tick;
    a_drv = 8'h22;
    tick;
    ctl.a_ld = 1'b0; a_en = 1'b0;
    chk8("rovr.b", b_bus, 8'h11);
    chk_flags("rovr", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ctl.ovr_clr = 1'b1;
    tick;
    ctl.ovr_clr = 1'b0;
    chk1("rovr.clr", ctl.ovr_r, 1'b0);

    // Overrun set beats a simultaneous clear.
    a_en = 1'b1; a_drv = 8'h33; ctl.a_ld = 1'b1; ctl.ovr_clr = 1'b1;
    tick;
    ctl.a_ld = 1'b0; a_en = 1'b0; ctl.ovr_clr = 1'b0;
    chk1("setwins.ovr_r", ctl.ovr_r, 1'b1);
    chk8("setwins.b", b_bus, 8'h11);
    ctl.ovr_clr = 1'b1; ctl.r_ack = 1'b1;
    tick;
    ctl.ovr_clr = 1'b0; ctl.r_ack = 1'b0;
    chk_flags("rclean", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ctl.b_oe_ = 1'b1;
    #1;

    // S load then simultaneous load+ack.
    b_en = 1'b1; b_drv = 8'h33; ctl.b_ld = 1'b1; ctl.ies = 1'b1;
    tick;
    chk1("s1.fs", ctl.fs, 1'b1);
    b_drv = 8'h44; ctl.s_ack = 1'b1;
    tick;
    ctl.b_ld = 1'b0; ctl.s_ack = 1'b0; b_en = 1'b0;
    chk_flags("sldack", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ctl.a_oe_ = 1'b0;
    #1;
    chk8("sldack.a", a_bus, 8'h44);
    ctl.a_oe_ = 1'b1;
    ctl.s_ack = 1'b1;
    tick;
    ctl.s_ack = 1'b0;
    chk_flags("sack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Both channels loaded in the same cycle.
    a_en = 1'b1; a_drv = 8'h5A; ctl.a_ld = 1'b1;
    b_en = 1'b1; b_drv = 8'hC3; ctl.b_ld = 1'b1;
    tick;
    ctl.a_ld = 1'b0; ctl.b_ld = 1'b0; a_en = 1'b0; b_en = 1'b0;
    ctl.ier = 1'b0; ctl.ies = 1'b1;
    ctl.a_oe_ = 1'b0; ctl.b_oe_ = 1'b0;
    #1;
    chk_flags("indep", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk8("indep.a", a_bus, 8'hC3);
    chk8("indep.b", b_bus, 8'h5A);
    ctl.ies = 1'b0;
    #1;
    chk1("indep.int_masked", ctl.int_, 1'b1);
    ctl.ies = 1'b1;
    @(negedge clk);

    // Loopback: R captures S through the a bus, with an ack freeing the full slot.
    ctl.a_ld = 1'b1; ctl.r_ack = 1'b1;
    tick;
    ctl.a_ld = 1'b0; ctl.r_ack = 1'b0;
    chk8("loop.b", b_bus, 8'hC3);
    chk_flags("loop", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overrun on S, then asynchronous reset between edges.
    ctl.b_ld = 1'b1;
    tick;
    ctl.b_ld = 1'b0;
    chk_flags("sovr", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    rst_ = 1'b0;
    #1;
    chk_flags("arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk8("arst.a_z", a_bus, 8'hFF);
    chk8("arst.b_z", b_bus, 8'hFF);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    chk8("arst.r_cleared", b_bus, 8'h00);
    chk8("arst.s_cleared", a_bus, 8'h00);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
